proc_insn_issue: RTL
====================

Name: proc_insn_issue

Overview:
- Writer side of the proc instruction store.
- Accepts decoded instruction fields (op, rd, rs1, rs2) over a valid/ready handshake and packs each into the 8-bit instruction word layout the proc core decodes. Writes the word into the ir array at a wrapping write pointer.
- Tracks occupancy against the core's retirement (step) pulses, so unretired instructions are never overwritten.
- Provides a flush sequence and a saturating issue counter for property checking.

Parameters:
- AW, 8, address width of the ir array; depth = 2^AW; pointer wrap matches the core pc.
- OP_ADD, 2'd1, opcode value that is accepted and written.
- CNT_W, 8, width of the saturating issue counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  instruction request valid.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_op  in  2  opcode; word bits [7:6].
- req_rd  in  2  destination register; bits [5:4].
- req_rs1  in  2  source 1; bits [3:2].
- req_rs2  in  2  source 2; bits [1:0].
- core_step  in  1  one-cycle pulse; core retired the word at the read pointer (pc advanced).
- flush  in  1  level; request a drain to empty.
- ir_we  out  1  ir array write enable.
- ir_waddr  out  AW  ir array write address.
- ir_wdata  out  8  packed word {op, rd, rs1, rs2}.
- count  out  AW+1  occupancy, 0..2^AW.
- full  out  1  count == 2^AW.
- empty  out  1  count == 0.
- illegal  out  1  one-cycle pulse: a non-OP_ADD request was consumed and dropped.
- underflow  out  1  sticky: core_step arrived while empty.
- flush_done  out  1  one-cycle pulse when a flush completes.
- issued  out  CNT_W  saturating count of written instructions.

Behaviour:
Reset (rst low at a clock edge):
- All state is cleared: write pointer, read pointer, count, issued, underflow.
- ir_we, illegal and flush_done are 0; ir_waddr and ir_wdata are 0.
- State goes to IDLE.
- Reset mid-flush or mid-write abandons the operation; no write follows reset.

State machine:
- IDLE → ACTIVE on the first req_valid. IDLE accepts in the same cycle as ACTIVE does.
- ACTIVE → FLUSH when flush is high.
- FLUSH: req_ready = 0; waits until count == 0 with no pending write.
- FLUSH → IDLE on that condition, pulsing flush_done in that cycle.
- A flush asserted while already empty completes on the next clock edge.

Handshake and write timing:
- req_ready = !full && state != FLUSH.
- Accept = req_valid && req_ready.
- On accept with req_op == OP_ADD:
  - The next cycle, ir_we = 1 for exactly one cycle, with ir_waddr = wptr and ir_wdata = the packed word.
  - wptr increments modulo 2^AW; count increments; issued increments, saturating at 2^CNT_W−1.
- On accept with any other op: nothing is written, count and issued are unchanged, and illegal pulses the next cycle.
- Back-to-back accepts give a write every cycle, one cycle of latency each.

Retirement:
- core_step while count > 0: rptr increments modulo 2^AW and count decrements.
- core_step while count == 0: ignored and underflow is set; it stays set until reset.
- Accept and step in the same cycle: count is unchanged and both pointers advance.
- A step in the same cycle as count reaching 2^AW frees a slot; req_ready reflects the registered count on the next cycle.

Invariants:
- count == wptr − rptr (modulo 2^AW), disambiguated by the full flag.
- Count never exceeds 2^AW.
- No write is issued while full.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants (OP_ADD = 2'd1);
  - field bit positions (OP [7:6], RD [5:4], RS1 [3:2], RS2 [1:0]);
  - the state enum (IDLE, ACTIVE, FLUSH).
- One natural sub-module: proc_insn_pack, a combinational field packer and legal-op check. It is the exact inverse of the core's field extraction and is reusable by benches.

Test Plan:
1. Reset, then one request op=1, rd=2, rs1=1, rs2=3 → the following cycle ir_we=1, ir_waddr=0, ir_wdata=8'h67; count=1; issued=1; state ACTIVE.
2. 256 back-to-back OP_ADD requests, no steps → full=1 and req_ready=0 after the 256th; a 257th valid is stalled; one core_step → req_ready=1 next cycle; the next write goes to address 0 (wrap).
3. Request with op=2 → no ir_we; illegal pulses once; count and issued are unchanged.
4. core_step with count=0 → underflow=1 and stays set; count stays 0. Accept and step in the same cycle at count=5 → count stays 5.
5. flush at count=3 → req_ready=0 immediately; after 3 steps, flush_done pulses in the same cycle count reaches 0; state returns to IDLE.
6. rst driven low during FLUSH with count=4 → next cycle count=0, ir_we=0, state IDLE; 300 writes afterwards → issued saturates at 255.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the proc instruction store: opcode values,
// instruction word field layout and the issue-side state encoding.
package proc_pkg;

    localparam logic [1:0] OP_ADD = 2'd1;

    localparam int WORD_W = 8;
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS1_HI = 3;
    localparam int RS1_LO = 2;
    localparam int RS2_HI = 1;
    localparam int RS2_LO = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/proc_insn_pack.sv
// Combinational packer: places decoded fields at the bit positions the core
// extracts them from, and flags whether the opcode is one the core executes.
module proc_insn_pack
    import proc_pkg::*;
#(
    parameter logic [1:0] LEGAL_OP = OP_ADD
) (
    input  logic [1:0]        op,
    input  logic [1:0]        rd,
    input  logic [1:0]        rs1,
    input  logic [1:0]        rs2,
    output logic [WORD_W-1:0] word,
    output logic              legal
);

    always_comb begin
        word                = '0;
        word[OP_HI:OP_LO]   = op;
        word[RD_HI:RD_LO]   = rd;
        word[RS1_HI:RS1_LO] = rs1;
        word[RS2_HI:RS2_LO] = rs2;
    end

    assign legal = (op == LEGAL_OP);

endmodule

// File: rtl/proc_insn_issue.sv
// Writer side of the proc instruction store: accepts decoded instructions,
// writes packed words at a wrapping pointer and tracks occupancy vs. retirement.
module proc_insn_issue #(
    parameter int         AW     = 8,
    parameter logic [1:0] OP_ADD = proc_pkg::OP_ADD,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [1:0]       req_rd,
    input  logic [1:0]       req_rs1,
    input  logic [1:0]       req_rs2,
    input  logic             core_step,
    input  logic             flush,
    output logic             ir_we,
    output logic [AW-1:0]    ir_waddr,
    output logic [7:0]       ir_wdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             illegal,
    output logic             underflow,
    output logic             flush_done,
    output logic [CNT_W-1:0] issued
);
    import proc_pkg::*;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    issue_state_e state_q, state_d;

    logic [AW-1:0]     wptr, rptr;
    logic [WORD_W-1:0] word_p0;
    logic              legal_p0;
    logic              accept_p0;
    logic              inc_p0, dec_p0;

    proc_insn_pack #(
        .LEGAL_OP(OP_ADD)
    ) u_pack (
        .op   (req_op),
        .rd   (req_rd),
        .rs1  (req_rs1),
        .rs2  (req_rs2),
        .word (word_p0),
        .legal(legal_p0)
    );

    assign full      = (count == DEPTH);
    assign empty     = (count == '0);
    assign accept_p0 = req_valid && req_ready;
    assign inc_p0    = accept_p0 && legal_p0;
    assign dec_p0    = core_step && !empty;

    // A flush may only finish once the last accepted write has landed.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        req_ready  = !full && (state_q != FLUSH);
        unique case (state_q)
            IDLE:    if (req_valid) state_d = ACTIVE;
            ACTIVE:  if (flush) state_d = FLUSH;
            FLUSH: begin
                if (empty && !ir_we) begin
                    state_d    = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // p0 -> p1: accepted request becomes a registered array write
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            issued    <= '0;
            underflow <= 1'b0;
            ir_we     <= 1'b0;
            illegal   <= 1'b0;
            ir_waddr  <= '0;
            ir_wdata  <= '0;
        end else begin
            state_q <= state_d;
            ir_we   <= inc_p0;
            illegal <= accept_p0 && !legal_p0;
            if (inc_p0) begin
                ir_waddr <= wptr;
                ir_wdata <= word_p0;
                wptr     <= wptr + AW'(1);
                issued   <= sat_inc(issued);
            end
            if (dec_p0) rptr <= rptr + AW'(1);
            if (core_step && empty) underflow <= 1'b1;
            count <= count + {{AW{1'b0}}, inc_p0} - {{AW{1'b0}}, dec_p0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) assert (count[AW-1:0] == wptr - rptr);
    end

endmodule
